// File: rtl/mem_lsu_stage.sv
// Memory stage: LOAD/STORE over a req/gnt/rvalid port, link-address forwarding for AUIPC/JAL/JALR.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses skip memory and report misalign_o.
module mem_lsu_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ack_o,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   result_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              ack_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [XLEN-1:0]   data_o,
  output logic              misalign_o
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [NB-1:0]     be_q, be_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, hold_q, hold_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d, cmis_q, cmis_d;
  logic [31:0]       cinstr_q, cinstr_d, instr_q, instr_d;
  logic              valid_q, valid_d, mis_q, mis_d;
  logic [XLEN-1:0]   data_q, data_d;

  logic [6:0]        opcode;
  logic [2:0]        funct3, amask;
  logic [1:0]        sz_in;
  logic [OFFW-1:0]   off_raw, off_in;
  logic              is_mem, is_link, mis_in, out_free;
  logic [NB-1:0]     bmask;
  logic [XLEN-1:0]   wdata_in, rshift, ext;

  // Decode of the instruction currently offered by EX.
  always_comb begin
    opcode  = instr_i[6:0];
    funct3  = instr_i[14:12];
    is_mem  = (opcode == OP_LOAD) || (opcode == OP_STORE);
    is_link = (opcode == OP_AUIPC) || (opcode == OP_JAL) || (opcode == OP_JALR);
    sz_in   = funct3[1:0];
    if (XLEN == 32 && sz_in == 2'd3) sz_in = 2'd2;
    case (sz_in)
      2'd0:    begin amask = 3'd0; bmask = NB'(1);  wdata_in = {NB{rs2_i[7:0]}};     end
      2'd1:    begin amask = 3'd1; bmask = NB'(3);  wdata_in = {(NB/2){rs2_i[15:0]}}; end
      2'd2:    begin amask = 3'd3; bmask = NB'(15); wdata_in = {(NB/4){rs2_i[31:0]}}; end
      default: begin amask = 3'd7; bmask = '1;      wdata_in = rs2_i;                 end
    endcase
    off_raw = result_i[OFFW-1:0];
    mis_in  = TRAP_EN && ((off_raw & OFFW'(amask)) != '0);
    off_in  = TRAP_EN ? off_raw : (off_raw & ~OFFW'(amask));
  end

  // Lane extraction and extension of returning load data.
  always_comb begin
    rshift = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ext = uns_q ? XLEN'(rshift[7:0])  : XLEN'($signed(rshift[7:0]));
      2'd1:    ext = uns_q ? XLEN'(rshift[15:0]) : XLEN'($signed(rshift[15:0]));
      2'd2:    ext = uns_q ? XLEN'(rshift[31:0]) : XLEN'($signed(rshift[31:0]));
      default: ext = rshift;
    endcase
  end

  assign out_free = !valid_q || ack_i;

  always_comb begin
    state_d  = state_q;  req_d   = req_q;   we_d    = we_q;    be_d    = be_q;
    addr_d   = addr_q;   wdata_d = wdata_q; hold_d  = hold_q;  off_d   = off_q;
    size_d   = size_q;   uns_d   = uns_q;   cmis_d  = cmis_q;  cinstr_d = cinstr_q;
    valid_d  = valid_q;  instr_d = instr_q; data_d  = data_q;  mis_d   = mis_q;
    ack_o    = 1'b0;
    if (ack_i) valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && is_mem) begin
          // Memory ops are captured even under back-pressure; DONE waits for space.
          ack_o    = 1'b1;
          cinstr_d = instr_i;
          off_d    = off_in;
          size_d   = sz_in;
          uns_d    = funct3[2];
          hold_d   = result_i;
          we_d     = (opcode == OP_STORE);
          be_d     = bmask << off_in;
          addr_d   = {result_i[XLEN-1:OFFW], {OFFW{1'b0}}};
          wdata_d  = wdata_in;
          cmis_d   = mis_in;
          if (mis_in) begin
            state_d = S_DONE;
          end else begin
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end else if (valid_i && out_free) begin
          ack_o   = 1'b1;
          valid_d = 1'b1;
          instr_d = instr_i;
          data_d  = is_link ? (pc_i + XLEN'(4)) : result_i;
          mis_d   = 1'b0;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          hold_d  = ext;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_free) begin
          valid_d = 1'b1;
          instr_d = cinstr_q;
          data_d  = hold_q;
          mis_d   = cmis_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q  <= S_IDLE; req_q   <= 1'b0; we_q    <= 1'b0; be_q   <= '0;
      addr_q   <= '0;     wdata_q <= '0;   hold_q  <= '0;   off_q  <= '0;
      size_q   <= '0;     uns_q   <= 1'b0; cmis_q  <= 1'b0; cinstr_q <= '0;
      valid_q  <= 1'b0;   instr_q <= '0;   data_q  <= '0;   mis_q  <= 1'b0;
    end else begin
      state_q  <= state_d; req_q   <= req_d;   we_q    <= we_d;    be_q   <= be_d;
      addr_q   <= addr_d;  wdata_q <= wdata_d; hold_q  <= hold_d;  off_q  <= off_d;
      size_q   <= size_d;  uns_q   <= uns_d;   cmis_q  <= cmis_d;  cinstr_q <= cinstr_d;
      valid_q  <= valid_d; instr_q <= instr_d; data_q  <= data_d;  mis_q  <= mis_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign valid_o     = valid_q;
  assign instr_o     = instr_q;
  assign data_o      = data_q;
  assign misalign_o  = mis_q;
endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed-vector bench for mem_lsu_stage at XLEN=32; inputs driven and outputs sampled on the falling edge.
module tb_mem_lsu_stage;
  logic        clk, rst_i, valid_i, ack_o, ack_i;
  logic [31:0] instr_i, result_i, rs2_i, pc_i;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        valid_o, misalign_o;
  logic [31:0] instr_o, data_o;

  int vec_cnt = 0;
  int miscmp  = 0;

  localparam logic [31:0] I_ADDI = 32'h00000093, I_AUIPC = 32'h00000097, I_JAL = 32'h0000006F;
  localparam logic [31:0] I_LB = 32'h00000083, I_LBU = 32'h00004083, I_LH = 32'h00001083;
  localparam logic [31:0] I_LHU = 32'h00005083, I_LW = 32'h00002083;
  localparam logic [31:0] I_SB = 32'h00000023, I_SH = 32'h00001023, I_SW = 32'h00002023;

  mem_lsu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_i(rst_i), .valid_i(valid_i), .ack_o(ack_o), .instr_i(instr_i),
    .result_i(result_i), .rs2_i(rs2_i), .pc_i(pc_i), .mem_req_o(mem_req_o),
    .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .ack_i(ack_i), .valid_o(valid_o), .instr_o(instr_o), .data_o(data_o), .misalign_o(misalign_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One memory transaction: gdly stall cycles before gnt, rdly stall cycles before rvalid.
  task automatic run_mem(input string tag, input logic [31:0] ins, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int gdly, input int rdly,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    logic is_st;
    is_st = (ins[6:0] == 7'b0100011);
    @(negedge clk);
    valid_i = 1'b1; instr_i = ins; result_i = addr; rs2_i = wd;
    #1 chk({tag, ".ack"}, ack_o, 1);
    for (int g = 0; g <= gdly; g++) begin
      @(negedge clk);
      valid_i = 1'b0;
      mem_rvalid_i = (g < gdly); mem_rdata_i = 32'hDEADBEEF;
      mem_gnt_i = (g == gdly);
      #1;
      chk({tag, ".req"}, mem_req_o, 1);
      chk({tag, ".addr"}, mem_addr_o, exp_addr);
      chk({tag, ".be"}, mem_be_o, exp_be);
      chk({tag, ".we"}, mem_we_o, is_st);
      if (is_st) chk({tag, ".wdata"}, mem_wdata_o, exp_wdata);
    end
    if (!is_st) begin
      for (int r = 0; r <= rdly; r++) begin
        @(negedge clk);
        mem_gnt_i = 1'b0;
        mem_rvalid_i = (r == rdly); mem_rdata_i = rd;
        #1 chk({tag, ".req_low"}, mem_req_o, 0);
      end
    end
    @(negedge clk);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #1 chk({tag, ".done_vld"}, valid_o, 0);
    @(negedge clk);
    #1;
    chk({tag, ".vld"}, valid_o, 1);
    chk({tag, ".data"}, data_o, exp_data);
    chk({tag, ".instr"}, instr_o, ins);
    chk({tag, ".mis"}, misalign_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ack_i = 1'b1; instr_i = '0; result_i = '0; rs2_i = '0;
    pc_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid_o", valid_o, 0);
    chk("rst.data_o", data_o, 0);
    chk("rst.instr_o", instr_o, 0);
    chk("rst.req", mem_req_o, 0);
    chk("rst.be", mem_be_o, 0);
    chk("rst.addr", mem_addr_o, 0);
    chk("rst.mis", misalign_o, 0);
    rst_i = 1'b0;

    // Non-memory pass-through, back-to-back with link forwarding.
    @(negedge clk);
    valid_i = 1'b1; instr_i = I_ADDI; result_i = 32'h1234; pc_i = 32'h400;
    #1 chk("addi.ack", ack_o, 1);
    @(negedge clk);
    instr_i = I_AUIPC; result_i = 32'h9999;
    #1;
    chk("addi.vld", valid_o, 1);
    chk("addi.data", data_o, 32'h1234);
    chk("auipc.ack", ack_o, 1);
    @(negedge clk);
    instr_i = I_JAL; pc_i = 32'h1000;
    #1;
    chk("auipc.data", data_o, 32'h404);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    chk("jal.vld", valid_o, 1);
    chk("jal.data", data_o, 32'h1004);
    @(negedge clk);
    #1 chk("idle.vld", valid_o, 0);

    run_mem("lb",  I_LB,  32'h103, 0, 32'h80FFFF00, 0, 0, 32'h100, 4'b1000, 0, 32'hFFFFFF80);
    run_mem("lbu", I_LBU, 32'h103, 0, 32'h80FFFF00, 0, 0, 32'h100, 4'b1000, 0, 32'h00000080);
    run_mem("lh",  I_LH,  32'h102, 0, 32'h80010000, 1, 0, 32'h100, 4'b1100, 0, 32'hFFFF8001);
    run_mem("lhu", I_LHU, 32'h102, 0, 32'h80010000, 0, 2, 32'h100, 4'b1100, 0, 32'h00008001);
    run_mem("lw",  I_LW,  32'h204, 0, 32'hCAFEF00D, 0, 1, 32'h204, 4'b1111, 0, 32'hCAFEF00D);
    run_mem("sh",  I_SH,  32'h102, 32'hABCD, 0, 3, 0, 32'h100, 4'b1100, 32'hABCDABCD, 32'h102);
    run_mem("sb",  I_SB,  32'h101, 32'h123456A5, 0, 0, 0, 32'h100, 4'b0010, 32'hA5A5A5A5, 32'h101);
    run_mem("sw",  I_SW,  32'h104, 32'hDEADBEEF, 0, 0, 0, 32'h104, 4'b1111, 32'hDEADBEEF, 32'h104);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    valid_i = 1'b1; instr_i = I_LW; result_i = 32'h102;
    #1 chk("mis.ack", ack_o, 1);
    @(negedge clk);
    valid_i = 1'b0;
    #1 chk("mis.req", mem_req_o, 0);
    @(negedge clk);
    #1;
    chk("mis.vld", valid_o, 1);
    chk("mis.data", data_o, 32'h102);
    chk("mis.flag", misalign_o, 1);
`else
    run_mem("lw_mis", I_LW, 32'h102, 0, 32'h11223344, 0, 0, 32'h100, 4'b1111, 0, 32'h11223344);
`endif

    // Back-pressure: load finishes while WB holds a stale output for 5 cycles.
    @(negedge clk);
    ack_i = 1'b0; valid_i = 1'b1; instr_i = I_ADDI; result_i = 32'h55;
    #1 chk("bp.addi_ack", ack_o, 1);
    @(negedge clk);
    instr_i = I_LW; result_i = 32'h100;
    #1 chk("bp.lw_ack", ack_o, 1);
    @(negedge clk);
    valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11223344;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_rvalid_i = 1'b0; valid_i = 1'b1; instr_i = I_ADDI; result_i = 32'h66;
      #1;
      chk("bp.ack_o", ack_o, 0);
      chk("bp.vld", valid_o, 1);
      chk("bp.data_held", data_o, 32'h55);
    end
    @(negedge clk);
    valid_i = 1'b0; ack_i = 1'b1;
    #1 chk("bp.data_pre", data_o, 32'h55);
    @(negedge clk);
    #1;
    chk("bp.vld_new", valid_o, 1);
    chk("bp.data_new", data_o, 32'h11223344);
    chk("bp.instr_new", instr_o, I_LW);

    // Reset in WAIT, late rvalid must be dropped.
    @(negedge clk);
    valid_i = 1'b1; instr_i = I_LW; result_i = 32'h200;
    #1 chk("rstw.ack", ack_o, 1);
    @(negedge clk);
    valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    chk("rstw.vld", valid_o, 0);
    chk("rstw.req", mem_req_o, 0);
    @(negedge clk);
    valid_i = 1'b1; instr_i = I_ADDI; result_i = 32'h77;
    #1;
    chk("rstw.vld2", valid_o, 0);
    chk("rstw.idle_ack", ack_o, 1);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    chk("rstw.after_vld", valid_o, 1);
    chk("rstw.after_data", data_o, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule

// File: doc/mem_lsu_stage.md
# mem_lsu_stage

Parametrised memory stage of the in-order pipeline, between EX and WB, replacing the single-cycle memory stage. It executes LOAD/STORE over a multi-cycle req/gnt/rvalid memory port, with byte-lane enables, store-data replication and sign/zero-extended sub-word loads. AUIPC/JAL/JALR forward pc+4 to WB; all other instructions forward result_i. XLEN is 32 or 64, and the valid/ack handshake towards EX and WB is unchanged.

## Interface
- XLEN, 32, datapath width; legal values 32, 64
- NB = XLEN/8 (localparam), byte lanes
- clk  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  EX holds a valid instruction
- ack_o  out  1  instruction consumed this cycle (combinational)
- instr_i  in  32  instruction word
- result_i  in  XLEN  ALU result / effective address
- rs2_i  in  XLEN  store data
- pc_i  in  XLEN  instruction pc
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  request accepted
- mem_addr_o  out  XLEN  NB-aligned address
- mem_we_o  out  1  1 = store
- mem_be_o  out  NB  byte enables
- mem_wdata_o  out  XLEN  lane-replicated store data
- mem_rvalid_i  in  1  load data valid
- mem_rdata_i  in  XLEN  load data
- ack_i  in  1  WB consumed the output
- valid_o  out  1  output register valid
- instr_o  out  32  instruction for WB
- data_o  out  XLEN  write-back data
- misalign_o  out  1  output instruction was a misaligned access

## Operation
- Opcodes (instr_i[6:0]): LOAD 0000011, STORE 0100011, AUIPC 0010111, JAL 1101111, JALR 1100111. Access size from funct3 = instr_i[14:12]. Funct3 011 (LD/SD) and 110 (LWU) are legal only when XLEN=64; at XLEN=32 they execute as LW/SW.
- Output space: `out_free = !valid_o || ack_i`.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, valid_i with a memory opcode:
  - ack_o=1 regardless of out_free.
  - Capture instr, offset = result_i[log2(NB)-1:0], be = size mask << offset, and wdata (byte replicated NB times, half replicated NB/2 times, word replicated NB/4 times).
  - Go to REQ.
- IDLE, valid_i with another opcode: if out_free, ack_o=1 and load the output register with {1, instr_i, pc_i+4 for AUIPC/JAL/JALR, else result_i}.
- REQ: mem_req_o=1. Address, we, be and wdata come from the captured registers and stay stable until gnt. On mem_gnt_i: store goes to DONE, load goes to WAIT.
- WAIT: on mem_rvalid_i:
  - Shift rdata right by offset×8.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU.
  - Hold the result, go to DONE.
- DONE: when out_free, load the output register with {1, instr, data} and go to IDLE. Data is the loaded value for a load and the effective address for a store.
- While not IDLE: ack_o=0.
- ack_i with no new load clears valid_o.
- mem_rvalid_i outside WAIT and mem_gnt_i outside REQ are ignored.

## Timing
- Reset: FSM=IDLE. valid_o, instr_o, data_o, misalign_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are all 0.
- Reset mid-transaction abandons it. No output is produced, and a late rvalid is ignored.
- Non-memory instruction: ack_o in cycle 0, valid_o in cycle 1. Back-to-back throughput is 1/cycle while ack_i is high.
- Load, gnt in the first REQ cycle, rvalid one cycle later: ack cycle 0, REQ 1, WAIT 2, DONE 3, valid_o cycle 4.
- Store with immediate gnt: valid_o in cycle 3.
- Each gnt or rvalid stall adds exactly one cycle per stall cycle.
- Back-pressure (ack_i=0, valid_o=1) holds DONE with no loss of data.
- valid_o and ack_i in the same cycle as DONE: the output is replaced in that cycle and valid_o stays 1.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - An access is misaligned when offset is not a multiple of the access size.
  - Capture goes IDLE→DONE directly; no mem_req_o is issued.
  - Output data_o = effective address with misalign_o=1.
  - misalign_o=0 for every other output.
- MEM_MISALIGN_TRAP_EN undefined:
  - offset is masked down to natural alignment (offset & ~(size-1)) before computing be and the extract shift.
  - misalign_o is tied to 0.

## Test plan
- XLEN=32, ADDI, result_i=0x1234, ack_i=1 → ack_o cycle 0, valid_o cycle 1, data_o=0x1234.
- LB from addr 0x103 with rdata 0x80FF_FF00, gnt and rvalid each immediate → mem_addr_o=0x100, be=1000b, data_o=0xFFFF_FF80 in cycle 4. LBU on the same inputs → 0x0000_0080.
- SH at 0x102 with rs2=0xABCD and gnt delayed 3 cycles → be=1100b, wdata=0xABCD_ABCD, req held stable for 4 cycles, valid_o 3 cycles later than the no-stall case.
- Load complete while ack_i=0 and valid_o=1 for 5 cycles → FSM stays in DONE, ack_o=0, no loss of data; output updated on the cycle ack_i rises.
- With MEM_MISALIGN_TRAP_EN, LW at 0x102 → no mem_req_o, misalign_o=1, data_o=0x102. Without the macro → be=1111b at 0x100.
- rst_i asserted in WAIT, rvalid arriving 1 cycle later → valid_o stays 0 and the FSM is IDLE.
